// File: rtl/tts_pkg.sv
// Shared types and constants for the truth-table sweeper.
package tts_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        SAMPLE,
        DONE
    } tts_state_e;

    localparam int N_VEC = 16;
    localparam int VEC_W = 4;

    // Golden table of the 4-input circuit: output is 0 only for vectors 11 and 15.
    localparam logic [N_VEC-1:0] EXP_DA1 = 16'h77FF;

endpackage

// File: rtl/truth_table_sweeper.sv
// Walks all 16 input vectors through the external logic circuit and packs its responses into a signature.
// Optional first-failure logging is enabled with the macro TTS_ERRLOG_EN.
module truth_table_sweeper
    import tts_pkg::*;
#(
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [N_VEC-1:0] EXPECTED      = EXP_DA1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               vec_a,
    output logic               vec_b,
    output logic               vec_c,
    output logic               vec_d,
    input  logic               resp_in,
    output logic               busy,
    output logic               done,
    output logic [N_VEC-1:0]   signature,
    output logic [4:0]         ones_count,
    output logic               pass,
    output logic [VEC_W-1:0]   first_fail_idx,
    output logic               fail_valid
);

    localparam logic [3:0]       SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam logic [VEC_W-1:0] LAST_IDX    = VEC_W'(N_VEC - 1);

    tts_state_e       state;
    logic [VEC_W-1:0] idx;
    logic [3:0]       settle_cnt;

    // The stimulus bits are the registered vector index itself.
    assign vec_a = idx[0];
    assign vec_b = idx[1];
    assign vec_c = idx[2];
    assign vec_d = idx[3];

`ifndef TTS_ERRLOG_EN
    assign first_fail_idx = '0;
    assign fail_valid     = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            signature  <= '0;
            ones_count <= '0;
            pass       <= 1'b0;
`ifdef TTS_ERRLOG_EN
            first_fail_idx <= '0;
            fail_valid     <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state      <= SETTLE;
                        idx        <= '0;
                        settle_cnt <= '0;
                        busy       <= 1'b1;
                        signature  <= '0;
                        ones_count <= '0;
                        pass       <= 1'b0;
`ifdef TTS_ERRLOG_EN
                        first_fail_idx <= '0;
                        fail_valid     <= 1'b0;
`endif
                    end
                end
                SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    signature[idx] <= resp_in;
                    ones_count     <= ones_count + {4'b0000, resp_in};
`ifdef TTS_ERRLOG_EN
                    if ((resp_in != EXPECTED[idx]) && !fail_valid) begin
                        first_fail_idx <= idx;
                        fail_valid     <= 1'b1;
                    end
`endif
                    // Explicit exit at the last vector keeps idx (and vec_*) parked at 15.
                    if (idx == LAST_IDX) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 1'b1;
                        state <= SETTLE;
                    end
                end
                DONE: begin
                    done  <= 1'b1;
                    pass  <= (signature == EXPECTED);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Randomized bench for truth_table_sweeper: two instances (settle 2 and settle 1) driven by table-based circuit models.
module tb_truth_table_sweeper;

    localparam logic [15:0] GOLDEN = 16'h77FF;

    logic        clk = 1'b0;
    logic        rst_n_v   [2];
    logic        start_v   [2];
    logic [15:0] tab       [2];
    logic        va [2], vb [2], vc [2], vd [2];
    logic [3:0]  vec_v     [2];
    logic        resp_v    [2];
    logic        busy_v    [2];
    logic        done_v    [2];
    logic [15:0] sig_v     [2];
    logic [4:0]  ones_v    [2];
    logic        pass_v    [2];
    logic [3:0]  ffi_v     [2];
    logic        fv_v      [2];

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    // The circuit under test is modelled as a lookup of the current vector.
    assign vec_v[0]  = {vd[0], vc[0], vb[0], va[0]};
    assign vec_v[1]  = {vd[1], vc[1], vb[1], va[1]};
    assign resp_v[0] = tab[0][vec_v[0]];
    assign resp_v[1] = tab[1][vec_v[1]];

    truth_table_sweeper dut0 (
        .clk(clk), .rst_n(rst_n_v[0]), .start(start_v[0]),
        .vec_a(va[0]), .vec_b(vb[0]), .vec_c(vc[0]), .vec_d(vd[0]),
        .resp_in(resp_v[0]), .busy(busy_v[0]), .done(done_v[0]),
        .signature(sig_v[0]), .ones_count(ones_v[0]), .pass(pass_v[0]),
        .first_fail_idx(ffi_v[0]), .fail_valid(fv_v[0])
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1)) dut1 (
        .clk(clk), .rst_n(rst_n_v[1]), .start(start_v[1]),
        .vec_a(va[1]), .vec_b(vb[1]), .vec_c(vc[1]), .vec_d(vd[1]),
        .resp_in(resp_v[1]), .busy(busy_v[1]), .done(done_v[1]),
        .signature(sig_v[1]), .ones_count(ones_v[1]), .pass(pass_v[1]),
        .first_fail_idx(ffi_v[1]), .fail_valid(fv_v[1])
    );

    // One sweep on instance s with circuit table tv; expectations come from the table alone.
    task automatic run_sweep(input int s, input logic [15:0] tv, input int restart_at,
                             input int tail, input string name);
        int settle, exp_done, exp_ones, exp_ffi, cyc, done_cyc, vec_err, pass_err, extra;
        logic exp_fv;
        logic [3:0] exp_vec;
        settle   = (s == 0) ? 2 : 1;
        exp_done = 16 * (settle + 1) + 1;
        exp_ones = 0;
        exp_fv   = 1'b0;
        exp_ffi  = 0;
        for (int i = 0; i < 16; i++) begin
            exp_ones += int'(tv[i]);
            if (tv[i] != GOLDEN[i] && !exp_fv) begin
                exp_fv  = 1'b1;
                exp_ffi = i;
            end
        end
`ifndef TTS_ERRLOG_EN
        exp_fv  = 1'b0;
        exp_ffi = 0;
`endif
        tab[s]     = tv;
        start_v[s] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[s] = 1'b0;
        compared++;
        if (busy_v[s] !== 1'b1 || sig_v[s] !== 16'h0 || ones_v[s] !== 5'd0 || pass_v[s] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s start_clear: busy=%b sig=%h ones=%0d pass=%b, want busy=1 sig=0000 ones=0 pass=0",
                     name, busy_v[s], sig_v[s], ones_v[s], pass_v[s]);
        end
        cyc = 0; done_cyc = -1; vec_err = 0; pass_err = 0;
        while (done_cyc < 0 && cyc < 400) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            start_v[s] = (cyc == restart_at);
            if (done_v[s] === 1'b1) begin
                done_cyc = cyc;
            end else begin
                exp_vec = (cyc / (settle + 1) > 15) ? 4'd15 : 4'(cyc / (settle + 1));
                if (vec_v[s] !== exp_vec) vec_err++;
                if (pass_v[s] !== 1'b0) pass_err++;
            end
        end
        start_v[s] = 1'b0;
        compared++;
        if (done_cyc != exp_done) begin
            mismatched++;
            $display("[TB] FAIL %s done_cycle: got %0d want %0d", name, done_cyc, exp_done);
        end
        compared++;
        if (vec_err != 0) begin
            mismatched++;
            $display("[TB] FAIL %s vec_walk: %0d cycles off, want 0", name, vec_err);
        end
        compared++;
        if (pass_err != 0) begin
            mismatched++;
            $display("[TB] FAIL %s pass_low: pass high in %0d cycles, want 0", name, pass_err);
        end
        compared++;
        if (sig_v[s] !== tv || ones_v[s] !== 5'(exp_ones) || pass_v[s] !== (tv == GOLDEN) || busy_v[s] !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL %s result: sig=%h ones=%0d pass=%b busy=%b, want sig=%h ones=%0d pass=%b busy=0",
                     name, sig_v[s], ones_v[s], pass_v[s], busy_v[s], tv, exp_ones, (tv == GOLDEN));
        end
        compared++;
        if (fv_v[s] !== exp_fv || ffi_v[s] !== 4'(exp_ffi)) begin
            mismatched++;
            $display("[TB] FAIL %s errlog: fail_valid=%b idx=%0d, want fail_valid=%b idx=%0d",
                     name, fv_v[s], ffi_v[s], exp_fv, exp_ffi);
        end
        if (tail > 0) begin
            extra = 0;
            repeat (tail) begin
                @(posedge clk);
                @(negedge clk);
                if (done_v[s] !== 1'b0) extra++;
            end
            compared++;
            if (extra != 0 || sig_v[s] !== tv || vec_v[s] !== 4'd15 || pass_v[s] !== (tv == GOLDEN)) begin
                mismatched++;
                $display("[TB] FAIL %s hold: extra_done=%0d sig=%h vec=%0d pass=%b, want 0 %h 15 %b",
                         name, extra, sig_v[s], vec_v[s], pass_v[s], tv, (tv == GOLDEN));
            end
        end
    endtask

    task automatic check_all_zero(input int s, input string name);
        compared++;
        if ({vec_v[s], busy_v[s], done_v[s], sig_v[s], ones_v[s], pass_v[s], ffi_v[s], fv_v[s]} !== 32'h0) begin
            mismatched++;
            $display("[TB] FAIL %s: vec=%0d busy=%b done=%b sig=%h ones=%0d pass=%b ffi=%0d fv=%b, want all 0",
                     name, vec_v[s], busy_v[s], done_v[s], sig_v[s], ones_v[s], pass_v[s], ffi_v[s], fv_v[s]);
        end
    endtask

    task automatic test_reset();
        rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;
        start_v[0] = 1'b0; start_v[1] = 1'b0;
        tab[0] = GOLDEN;   tab[1] = GOLDEN;
        #2;
        rst_n_v[0] = 1'b0; rst_n_v[1] = 1'b0;
        #1;
        check_all_zero(0, "reset_dut0");
        check_all_zero(1, "reset_dut1");
        repeat (3) @(negedge clk);
        rst_n_v[0] = 1'b1; rst_n_v[1] = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_real_circuit();
        run_sweep(0, GOLDEN, -1, 0, "real_circuit");
    endtask

    task automatic test_force_ones();
        run_sweep(0, 16'hFFFF, -1, 0, "force_ones");
    endtask

    task automatic test_restart_ignored();
        run_sweep(0, GOLDEN, 20, 4, "restart_ignored");
    endtask

    task automatic test_reset_midsweep();
        tab[0]     = GOLDEN;
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (30) @(posedge clk);
        #2;
        rst_n_v[0] = 1'b0;
        #1;
        check_all_zero(0, "reset_midsweep");
        @(negedge clk);
        rst_n_v[0] = 1'b1;
        repeat (5) @(negedge clk);
        check_all_zero(0, "reset_stays_idle");
        run_sweep(0, GOLDEN, -1, 0, "after_reset");
    endtask

    task automatic test_settle_one();
        run_sweep(1, GOLDEN, -1, 3, "settle1_real");
        run_sweep(1, 16'(($urandom)), -1, 0, "settle1_rand");
    endtask

    task automatic test_back_to_back();
        logic [15:0] tv;
        tv = 16'($urandom);
        run_sweep(0, tv, -1, 0, "b2b_first");
        run_sweep(0, tv, -1, 0, "b2b_second");
    endtask

    task automatic test_random();
        logic [15:0] tv;
        for (int k = 0; k < 4; k++) begin
            tv = 16'($urandom);
            if (k == 0) tv = GOLDEN ^ (16'h1 << $urandom_range(15, 0));
            run_sweep(0, tv, -1, 0, $sformatf("random%0d", k));
        end
    endtask

    initial begin
        test_reset();
        test_real_circuit();
        test_force_ones();
        test_restart_ignored();
        test_reset_midsweep();
        test_settle_one();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
